// File: rtl/processing_unit.sv
// Datapath of a small accumulator-free CPU: four GPRs, PC, IR, address register, ALU and two buses.
// Optional carry/borrow flag register Reg_C with output Cflag is enabled by defining PU_CARRY_FLAG_EN.
module processing_unit #(
   parameter int WORD_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Load_R0,
   input  logic                 Load_R1,
   input  logic                 Load_R2,
   input  logic                 Load_R3,
   input  logic                 Load_PC,
   input  logic                 Inc_PC,
   input  logic                 Load_IR,
   input  logic                 Load_Add_R,
   input  logic                 Load_Reg_Y,
   input  logic                 Load_Reg_Z,
   input  logic [2:0]           Sel_Bus_1_Mux,
   input  logic [1:0]           Sel_Bus_2_Mux,
   input  logic [WORD_SIZE-1:0] mem_word,
   output logic [WORD_SIZE-1:0] instruction,
   output logic                 Zflag,
`ifdef PU_CARRY_FLAG_EN
   output logic                 Cflag,
`endif
   output logic [WORD_SIZE-1:0] address,
   output logic [WORD_SIZE-1:0] Bus_1
);

   typedef enum logic [3:0] {
      OP_NOP = 4'b0000,
      OP_ADD = 4'b0001,
      OP_SUB = 4'b0010,
      OP_AND = 4'b0011,
      OP_NOT = 4'b0100
   } opcode_t;

   typedef enum logic [2:0] {
      SEL1_R0 = 3'd0,
      SEL1_R1 = 3'd1,
      SEL1_R2 = 3'd2,
      SEL1_R3 = 3'd3,
      SEL1_PC = 3'd4
   } sel_bus_1_t;

   typedef enum logic [1:0] {
      SEL2_ALU  = 2'd0,
      SEL2_BUS1 = 2'd1,
      SEL2_MEM  = 2'd2,
      SEL2_ZERO = 2'd3
   } sel_bus_2_t;

   logic [WORD_SIZE-1:0] r [4];
   logic [3:0]           load_r;
   logic [WORD_SIZE-1:0] pc;
   logic [WORD_SIZE-1:0] ir;
   logic [WORD_SIZE-1:0] add_r;
   logic [WORD_SIZE-1:0] reg_y;
   logic                 reg_z;

   logic [WORD_SIZE-1:0] bus_2;
   logic [WORD_SIZE-1:0] alu_out;
   logic                 alu_zero;
   opcode_t              opcode;

   assign load_r = {Load_R3, Load_R2, Load_R1, Load_R0};
   assign opcode = opcode_t'(ir[7:4]);

   // ---------------------------------------------------------------------
   // Buses
   // ---------------------------------------------------------------------
   // NOTE: every combinational output gets a default before the case so a
   // missing or X select can never infer a latch.
   always_comb begin
      Bus_1 = '0;
      case (Sel_Bus_1_Mux)
         SEL1_R0: Bus_1 = r[0];
         SEL1_R1: Bus_1 = r[1];
         SEL1_R2: Bus_1 = r[2];
         SEL1_R3: Bus_1 = r[3];
         SEL1_PC: Bus_1 = pc;
         default: Bus_1 = '0;
      endcase
   end

   always_comb begin
      bus_2 = '0;
      case (Sel_Bus_2_Mux)
         SEL2_ALU:  bus_2 = alu_out;
         SEL2_BUS1: bus_2 = Bus_1;
         SEL2_MEM:  bus_2 = mem_word;
         SEL2_ZERO: bus_2 = '0;
         default:   bus_2 = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // ALU: data_1 is Reg_Y, data_2 is Bus_1; results wrap
   // ---------------------------------------------------------------------
   always_comb begin
      alu_out = '0;
      case (opcode)
         OP_ADD:  alu_out = reg_y + Bus_1;
         OP_SUB:  alu_out = Bus_1 - reg_y;
         OP_AND:  alu_out = reg_y & Bus_1;
         OP_NOT:  alu_out = ~Bus_1;
         default: alu_out = '0;
      endcase
   end

   assign alu_zero = (alu_out == '0);

`ifdef PU_CARRY_FLAG_EN
   logic [WORD_SIZE:0] add_wide;
   logic               alu_carry;
   logic               reg_c;

   assign add_wide = {1'b0, reg_y} + {1'b0, Bus_1};

   always_comb begin
      alu_carry = 1'b0;
      case (opcode)
         OP_ADD:  alu_carry = add_wide[WORD_SIZE];
         OP_SUB:  alu_carry = (Bus_1 < reg_y);
         default: alu_carry = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         reg_c <= 1'b0;
      else if (Load_Reg_Z)
         reg_c <= alu_carry;
   end

   assign Cflag = reg_c;
`endif

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge bus value regardless of block ordering.
   // The register file is four flops, not a RAM, so it is reset like the rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            r[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (load_r[i])
               r[i] <= bus_2;
      end
   end

   // Load beats increment when both are asserted
   always_ff @(posedge clk) begin
      if (rst)
         pc <= '0;
      else if (Load_PC)
         pc <= bus_2;
      else if (Inc_PC)
         pc <= pc + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir    <= '0;
         add_r <= '0;
         reg_y <= '0;
         reg_z <= 1'b0;
      end else begin
         if (Load_IR)
            ir <= bus_2;
         if (Load_Add_R)
            add_r <= bus_2;
         if (Load_Reg_Y)
            reg_y <= bus_2;
         if (Load_Reg_Z)
            reg_z <= alu_zero;
      end
   end

   assign instruction = ir;
   assign address     = add_r;
   assign Zflag       = reg_z;

endmodule

// File: tb/tb_processing_unit.sv
// Directed self-checking bench for processing_unit; registers are observed through Bus_1.
// Define PU_CARRY_FLAG_EN for both bench and RTL to also check Cflag.
module tb_processing_unit;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         Load_R0, Load_R1, Load_R2, Load_R3;
   logic         Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z;
   logic [2:0]   Sel_Bus_1_Mux;
   logic [1:0]   Sel_Bus_2_Mux;
   logic [W-1:0] mem_word;
   logic [W-1:0] instruction;
   logic         Zflag;
   logic [W-1:0] address;
   logic [W-1:0] Bus_1;
`ifdef PU_CARRY_FLAG_EN
   logic         Cflag;
`endif

   int tests = 0;
   int fails = 0;

   processing_unit #(.WORD_SIZE(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .Load_R0       (Load_R0),
      .Load_R1       (Load_R1),
      .Load_R2       (Load_R2),
      .Load_R3       (Load_R3),
      .Load_PC       (Load_PC),
      .Inc_PC        (Inc_PC),
      .Load_IR       (Load_IR),
      .Load_Add_R    (Load_Add_R),
      .Load_Reg_Y    (Load_Reg_Y),
      .Load_Reg_Z    (Load_Reg_Z),
      .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
      .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
      .mem_word      (mem_word),
      .instruction   (instruction),
      .Zflag         (Zflag),
`ifdef PU_CARRY_FLAG_EN
      .Cflag         (Cflag),
`endif
      .address       (address),
      .Bus_1         (Bus_1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      Load_R0 = 0; Load_R1 = 0; Load_R2 = 0; Load_R3 = 0;
      Load_PC = 0; Inc_PC = 0; Load_IR = 0; Load_Add_R = 0;
      Load_Reg_Y = 0; Load_Reg_Z = 0;
   endtask

   // dst: 0-3 Rn, 4 PC, 5 IR, 6 Add_R, 7 Reg_Y; value comes from mem_word
   task automatic put(input int dst, input logic [W-1:0] v);
      mem_word = v;
      Sel_Bus_2_Mux = 2'd2;
      case (dst)
         0: Load_R0 = 1;
         1: Load_R1 = 1;
         2: Load_R2 = 1;
         3: Load_R3 = 1;
         4: Load_PC = 1;
         5: Load_IR = 1;
         6: Load_Add_R = 1;
         default: Load_Reg_Y = 1;
      endcase
      tick;
      idle;
   endtask

   // Reg_Y <= Rn / PC through Bus_1 -> Bus_2
   task automatic load_y_from(input logic [2:0] sel);
      Sel_Bus_1_Mux = sel;
      Sel_Bus_2_Mux = 2'd1;
      Load_Reg_Y = 1;
      tick;
      idle;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] sel, input logic [W-1:0] exp);
      Sel_Bus_1_Mux = sel;
      #1;
      check(tag, Bus_1, exp);
   endtask

   initial begin
      idle;
      rst = 0;
      Sel_Bus_1_Mux = 3'd0;
      Sel_Bus_2_Mux = 2'd0;
      mem_word = '0;
      tick;

      // Reset with every strobe high and mem_word=AA
      rst = 1;
      Load_R0 = 1; Load_R1 = 1; Load_R2 = 1; Load_R3 = 1;
      Load_PC = 1; Inc_PC = 1; Load_IR = 1; Load_Add_R = 1;
      Load_Reg_Y = 1; Load_Reg_Z = 1;
      Sel_Bus_2_Mux = 2'd2;
      mem_word = 8'hAA;
      tick;
      rst = 0;
      idle;
      check("rst_instruction", instruction, 8'h00);
      check("rst_address", address, 8'h00);
      check("rst_zflag", {7'b0, Zflag}, 8'h00);
`ifdef PU_CARRY_FLAG_EN
      check("rst_cflag", {7'b0, Cflag}, 8'h00);
`endif
      check_reg("rst_r0", 3'd0, 8'h00);
      check_reg("rst_r1", 3'd1, 8'h00);
      check_reg("rst_r2", 3'd2, 8'h00);
      check_reg("rst_r3", 3'd3, 8'h00);
      check_reg("rst_pc", 3'd4, 8'h00);

      // Fetch
      put(4, 8'h05);
      Sel_Bus_1_Mux = 3'd4;
      Sel_Bus_2_Mux = 2'd1;
      Load_Add_R = 1;
      tick;
      idle;
      check("fetch_address", address, 8'h05);
      mem_word = 8'h12;
      Sel_Bus_2_Mux = 2'd2;
      Load_IR = 1;
      Inc_PC = 1;
      tick;
      idle;
      check("fetch_instruction", instruction, 8'h12);
      check_reg("fetch_pc_inc", 3'd4, 8'h06);

      // ADD R0,R1: FF + 03 = 102 -> 02 with carry
      put(0, 8'h03);
      put(1, 8'hFF);
      put(5, 8'h10);
      load_y_from(3'd1);
      Sel_Bus_1_Mux = 3'd0;
      Sel_Bus_2_Mux = 2'd0;
      Load_R0 = 1;
      Load_Reg_Z = 1;
      #1;
      check("add_pre_edge_r0", Bus_1, 8'h03);
      tick;
      idle;
      check_reg("add_r0", 3'd0, 8'h02);
      check("add_zflag", {7'b0, Zflag}, 8'h00);
`ifdef PU_CARRY_FLAG_EN
      check("add_cflag", {7'b0, Cflag}, 8'h01);
`endif
      check_reg("add_r1_hold", 3'd1, 8'hFF);

      // SUB R2,R3: 40 - 40 = 00
      put(2, 8'h40);
      put(3, 8'h40);
      put(5, 8'h2B);
      load_y_from(3'd3);
      Sel_Bus_1_Mux = 3'd2;
      Sel_Bus_2_Mux = 2'd0;
      Load_R2 = 1;
      Load_Reg_Z = 1;
      tick;
      idle;
      check_reg("sub_r2", 3'd2, 8'h00);
      check("sub_zflag", {7'b0, Zflag}, 8'h01);
`ifdef PU_CARRY_FLAG_EN
      check("sub_cflag", {7'b0, Cflag}, 8'h00);
`endif

      // SUB with borrow: 00 - 40 = C0
      Sel_Bus_1_Mux = 3'd2;
      Sel_Bus_2_Mux = 2'd0;
      Load_R1 = 1;
      Load_Reg_Z = 1;
      tick;
      idle;
      check_reg("subb_r1", 3'd1, 8'hC0);
      check("subb_zflag", {7'b0, Zflag}, 8'h00);
`ifdef PU_CARRY_FLAG_EN
      check("subb_cflag", {7'b0, Cflag}, 8'h01);
`endif

      // NOT R1 -> R0: ~C0 = 3F
      put(5, 8'h40);
      Sel_Bus_1_Mux = 3'd1;
      Sel_Bus_2_Mux = 2'd0;
      Load_R0 = 1;
      tick;
      idle;
      check_reg("not_r0", 3'd0, 8'h3F);

      // AND Y(40) & R0(3F) = 00 -> R3
      put(5, 8'h30);
      Sel_Bus_1_Mux = 3'd0;
      Sel_Bus_2_Mux = 2'd0;
      Load_R3 = 1;
      Load_Reg_Z = 1;
      tick;
      idle;
      check_reg("and_r3", 3'd3, 8'h00);
      check("and_zflag", {7'b0, Zflag}, 8'h01);

      // Unassigned opcode gives 0
      put(5, 8'hF0);
      Sel_Bus_1_Mux = 3'd1;
      Sel_Bus_2_Mux = 2'd0;
      Load_R0 = 1;
      tick;
      idle;
      check_reg("nop_r0", 3'd0, 8'h00);

      // PC wrap and load priority
      put(4, 8'hFF);
      Inc_PC = 1;
      tick;
      idle;
      check_reg("pc_wrap", 3'd4, 8'h00);
      put(4, 8'h10);
      mem_word = 8'h80;
      Sel_Bus_2_Mux = 2'd2;
      Load_PC = 1;
      Inc_PC = 1;
      tick;
      idle;
      check_reg("pc_load_wins", 3'd4, 8'h80);

      // Write path and unused selects
      put(3, 8'h5A);
      check_reg("bus1_r3", 3'd3, 8'h5A);
      check_reg("bus1_sel6", 3'd6, 8'h00);
      check_reg("bus1_sel5", 3'd5, 8'h00);
      check_reg("bus1_sel7", 3'd7, 8'h00);
      tick;
      check_reg("hold_r3", 3'd3, 8'h5A);
      check_reg("hold_pc", 3'd4, 8'h80);
      check("hold_address", address, 8'h05);
      check("hold_instruction", instruction, 8'hF0);

      // X selects with all strobes low
      Sel_Bus_1_Mux = 3'bxxx;
      Sel_Bus_2_Mux = 2'bxx;
      mem_word = 8'hxx;
      tick;
      tick;
      check_reg("x_r0", 3'd0, 8'h00);
      check_reg("x_r1", 3'd1, 8'hC0);
      check_reg("x_r2", 3'd2, 8'h00);
      check_reg("x_r3", 3'd3, 8'h5A);
      check_reg("x_pc", 3'd4, 8'h80);
      check("x_zflag", {7'b0, Zflag}, 8'h01);

      // Reset in the middle of an instruction
      mem_word = 8'h77;
      Sel_Bus_2_Mux = 2'd2;
      Load_R0 = 1;
      Load_PC = 1;
      Load_IR = 1;
      Load_Add_R = 1;
      rst = 1;
      tick;
      rst = 0;
      idle;
      check_reg("midrst_r0", 3'd0, 8'h00);
      check_reg("midrst_r3", 3'd3, 8'h00);
      check_reg("midrst_pc", 3'd4, 8'h00);
      check("midrst_instruction", instruction, 8'h00);
      check("midrst_address", address, 8'h00);
      check("midrst_zflag", {7'b0, Zflag}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/processing_unit.md
PROCESSING_UNIT -- requirements
Module: processing_unit

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 8, giving the data, address and instruction width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have ports Load_R0, Load_R1, Load_R2, Load_R3, input, 1 bit each: register load strobes from the control unit.
REQ-005 The module SHALL have ports Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, input, 1 bit each: load and increment strobes.
REQ-006 The module SHALL have port Sel_Bus_1_Mux, input, 3 bits: Bus_1 source select.
REQ-007 The module SHALL have port Sel_Bus_2_Mux, input, 2 bits: Bus_2 source select.
REQ-008 The module SHALL have port mem_word, input, WORD_SIZE bits: memory read data.
REQ-009 The module SHALL have port instruction, output, WORD_SIZE bits: IR contents, fed to the control unit.
REQ-010 The module SHALL have port Zflag, output, 1 bit: Reg_Z contents.
REQ-011 The module SHALL have port address, output, WORD_SIZE bits: Add_R contents, the memory address.
REQ-012 The module SHALL have port Bus_1, output, WORD_SIZE bits: memory write data.

Function
REQ-013 Bus_1 SHALL be combinational: select 0-3 gives R0-R3, 4 gives PC, 5-7 give zero.
REQ-014 Bus_2 SHALL be combinational: select 0 gives alu_out, 1 gives Bus_1, 2 gives mem_word, 3 gives zero.
REQ-015 The ALU SHALL be combinational, with data_1 = Reg_Y, data_2 = Bus_1, and opcode = IR[7:4].
REQ-016 ALU operations SHALL be: 0001 ADD data_1+data_2; 0010 SUB data_2-data_1; 0011 AND bitwise; 0100 NOT ~data_2; all other opcodes give 0.
REQ-017 ALU results SHALL wrap modulo 2^WORD_SIZE, with no saturation.
REQ-018 alu_zero SHALL be 1 when alu_out is 0.
REQ-019 On a rising edge, each register whose load strobe is high (R0-R3, IR, Add_R, Reg_Y) SHALL capture the Bus_2 value of that cycle.
REQ-020 Reg_Z SHALL capture alu_zero when Load_Reg_Z is high.
REQ-021 PC SHALL load Bus_2 when Load_PC is high; else increment by 1 (wrapping FF->00) when Inc_PC is high; else hold.
REQ-022 When Load_PC and Inc_PC are both high, Load_PC SHALL win.
REQ-023 Multiple simultaneous load strobes SHALL all take effect in the same cycle.
REQ-024 A register read on Bus_1 SHALL return its pre-edge value; write-to-read latency is one cycle.
REQ-025 Registers with no strobe asserted SHALL hold their value.
REQ-026 Unassigned or X selects SHALL NOT corrupt any register whose strobe is low.

Reset
REQ-027 When rst is high at a rising edge, R0-R3, PC, IR, Add_R, Reg_Y and Reg_Z SHALL all become 0, overriding every strobe.
REQ-028 Out of reset, instruction, address and Zflag SHALL be 0; the first fetch then uses address 00.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction, with no partial register update on that edge.

Configuration
REQ-030 Macro PU_CARRY_FLAG_EN: when defined, the module SHALL add output port Cflag (1 bit) driven by register Reg_C.
REQ-031 With PU_CARRY_FLAG_EN defined, Reg_C SHALL load on Load_Reg_Z: ADD carry-out, SUB borrow (data_2<data_1), 0 for other opcodes; Reg_C resets to 0.
REQ-032 When PU_CARRY_FLAG_EN is not defined, port Cflag and Reg_C SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset: rst=1 for one edge with all strobes high and mem_word=AA -> all registers 00, Zflag=0, address=00.
REQ-034 Fetch: PC=05, Sel1=4, Sel2=1, Load_Add_R -> address=05; next cycle mem_word=12, Sel2=2, Load_IR, Inc_PC -> instruction=12, PC=06.
REQ-035 ADD R0,R1: R0=03, R1=FF, IR=10; Reg_Y<=R1, then Sel1=0, Sel2=0, Load_R0, Load_Reg_Z -> R0=02, Zflag=0, Cflag=1 if enabled.
REQ-036 SUB zero: R2=R3=40, IR=2B (dst R2, src R3); Y<=R3, then Sel1=2, ex -> R2=00, Zflag=1.
REQ-037 Priority/wrap: PC=FF, Inc_PC alone -> 00; PC=10, Load_PC and Inc_PC with Bus_2=mem_word=80 -> PC=80.
REQ-038 Write path: R3=5A, Sel1=3 -> Bus_1=5A same cycle; Sel1=6 -> Bus_1=00; no register changes.
